// File: rtl/helo_pkg.sv
// Shared types and the index wrap rule for the HELLO rotation sequencer.
package helo_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t IDX_MAX = 3'd4;

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} scroll_state_t;

  // Wraps 4 -> 0 going up and 0 -> 4 going down, so 5..7 are never produced.
  function automatic sel_t next_idx(sel_t cur, logic dir);
    if (dir) begin
      return (cur == 3'd0) ? IDX_MAX : cur - 3'd1;
    end else begin
      return (cur >= IDX_MAX) ? 3'd0 : cur + 3'd1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle falling-edge pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  // Flops reset to 0, so a line that idles high after reset never fakes a fall.
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/helo_scroll_ctrl.sv
// Generates the 3-bit HELLO rotation select: timed scroll, pause with single-step, load.
module helo_scroll_ctrl
  import helo_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       run,
  input  logic       dir,
  input  logic       step_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       tick,
  output logic       running,
  output logic       load_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic          w_run_s;
  logic          w_run_fall_unused;
  logic          w_step_level_unused;
  logic          w_step_fall;
  logic          w_load_ok;

  scroll_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  sel_t             r_sel;
  logic             r_tick;
  logic             r_load_err;

  sync_edge_det u_run_sync (
    .i_clk   (CLOCK_50),
    .i_rst_n (RST_N),
    .i_async (run),
    .o_level (w_run_s),
    .o_fall  (w_run_fall_unused)
  );

  sync_edge_det u_step_sync (
    .i_clk   (CLOCK_50),
    .i_rst_n (RST_N),
    .i_async (step_n),
    .o_level (w_step_level_unused),
    .o_fall  (w_step_fall)
  );

  assign w_load_ok = load && (load_val <= IDX_MAX);

  // Priority: valid load, then step (PAUSED only), then timed advance (RUNNING only).
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= PAUSED;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_tick     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_load_err <= 1'b0;
      r_state    <= w_run_s ? RUNNING : PAUSED;
      if (w_load_ok) begin
        r_sel <= load_val;
        r_cnt <= '0;
      end else begin
        if (load) begin
          r_load_err <= 1'b1;
        end
        if (r_state == PAUSED) begin
          r_cnt <= '0;
          if (w_step_fall) begin
            r_sel <= next_idx(r_sel, dir);
          end
        end else if (!w_run_s) begin
          // Leaving RUNNING wins over a wrap in the same cycle: no tick.
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_sel  <= next_idx(r_sel, dir);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign sel      = r_sel;
  assign tick     = r_tick;
  assign running  = (r_state == RUNNING);
  assign load_err = r_load_err;

endmodule

// File: tb/tb_helo_scroll_ctrl.sv
// Directed bench for helo_scroll_ctrl with TICK_DIV=4; expected output events carry their cycle stamp.
module tb_helo_scroll_ctrl;

  localparam int EW = 38;

  logic       clk = 1'b0;
  logic       RST_N = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step_n = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] sel;
  logic       tick;
  logic       running;
  logic       load_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  // Event word: {cycle, sel, tick, load_err, running}
  logic [EW-1:0] exp_q[$];

  helo_scroll_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .RST_N    (RST_N),
    .run      (run),
    .dir      (dir),
    .step_n   (step_n),
    .load     (load),
    .load_val (load_val),
    .sel      (sel),
    .tick     (tick),
    .running  (running),
    .load_err (load_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tk();
  endtask

  task automatic push_exp(input int c, input logic [2:0] s, input logic t,
                          input logic e, input logic r);
    exp_q.push_back({c[31:0], s, t, e, r});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int r0;
    int q;
    #1 RST_N = 1'b0;
    repeat (3) tk();
    RST_N = 1'b1;
    tk();
    tk();

    // Timed scroll up from 0, then reverse direction mid-run.
    k = cyc;
    run = 1'b1;
    r0 = k + 3;
    push_exp(r0, 3'd0, 1'b0, 1'b0, 1'b1);
    push_exp(r0 + 4,  3'd1, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 8,  3'd2, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 12, 3'd3, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 16, 3'd4, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 20, 3'd0, 1'b1, 1'b0, 1'b1);
    wait_until(r0 + 20);
    dir = 1'b1;
    push_exp(r0 + 24, 3'd4, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 28, 3'd3, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 32, 3'd2, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 36, 3'd1, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 40, 3'd0, 1'b1, 1'b0, 1'b1);
    push_exp(r0 + 44, 3'd4, 1'b1, 1'b0, 1'b1);

    // Valid load on the wrap cycle: tick suppressed, next tick 4 cycles later.
    wait_until(r0 + 47);
    load = 1'b1;
    load_val = 3'd3;
    push_exp(r0 + 48, 3'd3, 1'b0, 1'b0, 1'b1);
    push_exp(r0 + 52, 3'd2, 1'b1, 1'b0, 1'b1);
    tk();
    load = 1'b0;

    // Rejected load on a wrap cycle: tick and advance still happen.
    wait_until(r0 + 55);
    load = 1'b1;
    load_val = 3'd7;
    push_exp(r0 + 56, 3'd1, 1'b1, 1'b1, 1'b1);
    tk();
    load = 1'b0;

    // Drop run so that leaving RUNNING lands on the wrap cycle.
    wait_until(r0 + 57);
    run = 1'b0;
    push_exp(r0 + 60, 3'd1, 1'b0, 1'b0, 1'b0);

    // Paused single-steps with a held button, twice.
    wait_until(r0 + 64);
    dir = 1'b0;
    for (int n = 0; n < 2; n++) begin
      k = cyc;
      step_n = 1'b0;
      push_exp(k + 3, (n == 0) ? 3'd2 : 3'd3, 1'b0, 1'b0, 1'b0);
      repeat (10) tk();
      step_n = 1'b1;
      repeat (5) tk();
    end

    // Rejected load coincident with a step: step still applied.
    k = cyc;
    step_n = 1'b0;
    wait_until(k + 2);
    load = 1'b1;
    load_val = 3'd6;
    push_exp(k + 3, 3'd4, 1'b0, 1'b1, 1'b0);
    tk();
    load = 1'b0;
    repeat (8) tk();
    step_n = 1'b1;
    repeat (5) tk();

    // Valid load coincident with a step: step dropped.
    k = cyc;
    step_n = 1'b0;
    wait_until(k + 2);
    load = 1'b1;
    load_val = 3'd2;
    push_exp(k + 3, 3'd2, 1'b0, 1'b0, 1'b0);
    tk();
    load = 1'b0;
    repeat (8) tk();
    step_n = 1'b1;
    repeat (5) tk();

    // Load boundaries: 4 accepted, 5 rejected, then back to 2.
    k = cyc;
    load = 1'b1;
    load_val = 3'd4;
    push_exp(k + 1, 3'd4, 1'b0, 1'b0, 1'b0);
    tk();
    load_val = 3'd5;
    push_exp(k + 2, 3'd4, 1'b0, 1'b1, 1'b0);
    tk();
    load = 1'b0;
    tk();
    k = cyc;
    load = 1'b1;
    load_val = 3'd2;
    push_exp(k + 1, 3'd2, 1'b0, 1'b0, 1'b0);
    tk();
    load = 1'b0;

    // Reset mid-count with sel=2, run held high through release.
    repeat (2) tk();
    k = cyc;
    run = 1'b1;
    push_exp(k + 3, 3'd2, 1'b0, 1'b0, 1'b1);
    wait_until(k + 5);
    RST_N = 1'b0;
    tk();
    tk();
    RST_N = 1'b1;
    q = cyc;
    push_exp(q + 3, 3'd0, 1'b0, 1'b0, 1'b1);
    push_exp(q + 7, 3'd1, 1'b1, 1'b0, 1'b1);
    wait_until(q + 7);
    run = 1'b0;
    push_exp(q + 10, 3'd1, 1'b0, 1'b0, 1'b0);

    k = cyc;
    while (exp_q.size() != 0 && cyc < k + 100) tk();
    repeat (12) tk();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [2:0]    prev_sel;
    logic          prev_run;
    logic [EW-1:0] got;
    logic [EW-1:0] exp_w;
    @(negedge clk or negedge RST_N);
    #1;
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: %0d left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    checks++;
    if (sel > 3'd4) begin
      errors++;
      $display("FAIL sel_range cyc=%0d sel=%0d, required <= 4", cyc, sel);
    end
    if (!RST_N) begin
      checks++;
      if ({sel, tick, load_err, running} !== 6'b000_0_0_0) begin
        errors++;
        $display("FAIL reset_values sel=%0d tick=%0b err=%0b run=%0b, required all 0",
                 sel, tick, load_err, running);
      end
    end else if (sel !== prev_sel || running !== prev_run || tick || load_err) begin
      got = {cyc[31:0], sel, tick, load_err, running};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d sel=%0d tick=%0b err=%0b run=%0b, required none",
                 cyc, sel, tick, load_err, running);
      end else begin
        exp_w = exp_q.pop_front();
        if (got !== exp_w) begin
          errors++;
          $display("FAIL event got cyc=%0d sel=%0d tick=%0b err=%0b run=%0b, required cyc=%0d sel=%0d tick=%0b err=%0b run=%0b",
                   cyc, sel, tick, load_err, running,
                   exp_w[37:6], exp_w[5:3], exp_w[2], exp_w[1], exp_w[0]);
        end
      end
    end
    prev_sel = sel;
    prev_run = running;
  end

endmodule
